// File: rtl/ram_port_arbiter.sv
// Arbitrates a simple dual-port block RAM between an instruction-fetch reader and a
// data read/write requester; writes use port A, reads use port B with 2-cycle latency.
module ram_port_arbiter #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 16,
   parameter int RR_MODE = 1
) (
   input  logic              clka,
   input  logic              rst,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              ram_ena,
   output logic              ram_wea,
   output logic [ADDR_W-1:0] ram_addra,
   output logic [DATA_W-1:0] ram_dia,
   output logic              ram_enb,
   output logic [ADDR_W-1:0] ram_addrb,
   input  logic [DATA_W-1:0] ram_dob
);

   typedef enum logic {
      RD_FETCH = 1'b0,
      RD_DATA  = 1'b1
   } rd_owner_t;

   logic              d_rd_s;
   logic              contend_s;
   logic              fetch_wins_s;
   logic              f_gnt_s;
   logic              d_gnt_s;
   logic              wr_acc_s;
   logic              rd_acc_s;
   rd_owner_t         rd_winner_s;
   logic [ADDR_W-1:0] rd_addr_s;

   rd_owner_t         last_rd_r;
   logic              wr_v_r;
   logic [ADDR_W-1:0] addra_r;
   logic [DATA_W-1:0] dia_r;
   logic              rd_v1_r;
   rd_owner_t         rd_tag1_r;
   logic [ADDR_W-1:0] addrb_r;
   logic              rd_v2_r;
   rd_owner_t         rd_tag2_r;
   logic [DATA_W-1:0] f_hold_r;
   logic [DATA_W-1:0] d_hold_r;

   // Grant decision: writes always pass, only two reads compete for port B.
   always_comb begin
      d_rd_s       = d_req && !d_we;
      contend_s    = f_req && d_rd_s;
      fetch_wins_s = 1'b0;
      f_gnt_s      = 1'b0;
      d_gnt_s      = 1'b0;
      if (RR_MODE != 32'sd0) begin
         fetch_wins_s = (last_rd_r == RD_DATA);
      end else begin
         fetch_wins_s = 1'b0;
      end
      if (rst) begin
         f_gnt_s = 1'b0;
         d_gnt_s = 1'b0;
      end else if (contend_s) begin
         f_gnt_s = fetch_wins_s;
         d_gnt_s = !fetch_wins_s;
      end else begin
         f_gnt_s = f_req;
         d_gnt_s = d_req;
      end
   end

   // Accepted transfers and the read winner feeding the port B pipeline.
   always_comb begin
      wr_acc_s    = d_req && d_we && d_gnt_s;
      rd_acc_s    = (f_req && f_gnt_s) || (d_rd_s && d_gnt_s);
      rd_winner_s = RD_FETCH;
      rd_addr_s   = f_addr;
      if (d_rd_s && d_gnt_s) begin
         rd_winner_s = RD_DATA;
         rd_addr_s   = d_addr;
      end else begin
         rd_winner_s = RD_FETCH;
         rd_addr_s   = f_addr;
      end
   end

   // Round-robin history; only contended cycles move it.
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         last_rd_r <= RD_DATA;
      end else if (contend_s) begin
         last_rd_r <= rd_winner_s;
      end else begin
         last_rd_r <= last_rd_r;
      end
   end

   // Port A write stage; an async reset cancels a write not yet performed.
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         wr_v_r  <= 1'b0;
         addra_r <= {ADDR_W{1'b0}};
         dia_r   <= {DATA_W{1'b0}};
      end else if (wr_acc_s) begin
         wr_v_r  <= 1'b1;
         addra_r <= d_addr;
         dia_r   <= d_wdata;
      end else begin
         wr_v_r  <= 1'b0;
         addra_r <= addra_r;
         dia_r   <= dia_r;
      end
   end

   // Port B read stage 1: enable, address and owner tag.
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         rd_v1_r   <= 1'b0;
         rd_tag1_r <= RD_FETCH;
         addrb_r   <= {ADDR_W{1'b0}};
      end else if (rd_acc_s) begin
         rd_v1_r   <= 1'b1;
         rd_tag1_r <= rd_winner_s;
         addrb_r   <= rd_addr_s;
      end else begin
         rd_v1_r   <= 1'b0;
         rd_tag1_r <= rd_tag1_r;
         addrb_r   <= addrb_r;
      end
   end

   // Port B read stage 2: data from the RAM output register is valid here.
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         rd_v2_r   <= 1'b0;
         rd_tag2_r <= RD_FETCH;
      end else begin
         rd_v2_r   <= rd_v1_r;
         rd_tag2_r <= rd_tag1_r;
      end
   end

   // Hold registers keep the last returned word between rvalid pulses.
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         f_hold_r <= {DATA_W{1'b0}};
         d_hold_r <= {DATA_W{1'b0}};
      end else if (rd_v2_r && (rd_tag2_r == RD_DATA)) begin
         f_hold_r <= f_hold_r;
         d_hold_r <= ram_dob;
      end else if (rd_v2_r) begin
         f_hold_r <= ram_dob;
         d_hold_r <= d_hold_r;
      end else begin
         f_hold_r <= f_hold_r;
         d_hold_r <= d_hold_r;
      end
   end

   assign f_gnt     = f_gnt_s;
   assign d_gnt     = d_gnt_s;
   assign ram_ena   = wr_v_r;
   assign ram_wea   = wr_v_r;
   assign ram_addra = addra_r;
   assign ram_dia   = dia_r;
   assign ram_enb   = rd_v1_r;
   assign ram_addrb = addrb_r;
   assign f_rvalid  = rd_v2_r && (rd_tag2_r == RD_FETCH);
   assign d_rvalid  = rd_v2_r && (rd_tag2_r == RD_DATA);
   // RAM output is itself registered, so it is forwarded straight through during the pulse.
   assign f_rdata   = f_rvalid ? ram_dob : f_hold_r;
   assign d_rdata   = d_rvalid ? ram_dob : d_hold_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a round-robin instance with a read-first RAM model,
// and a fixed-priority instance sharing the same stimulus for grant-order checks.
module tb_ram_port_arbiter;

   logic        clka = 1'b0;
   logic        rst;
   logic        f_req, d_req, d_we;
   logic [9:0]  f_addr, d_addr;
   logic [15:0] d_wdata;

   logic        f_gnt, f_rvalid, d_gnt, d_rvalid;
   logic [15:0] f_rdata, d_rdata;
   logic        ram_ena, ram_wea, ram_enb;
   logic [9:0]  ram_addra, ram_addrb;
   logic [15:0] ram_dia;
   logic [15:0] ram_dob = 16'h0000;

   logic        f_gnt0, f_rvalid0, d_gnt0, d_rvalid0;
   logic [15:0] f_rdata0, d_rdata0;
   logic        ram_ena0, ram_wea0, ram_enb0;
   logic [9:0]  ram_addra0, ram_addrb0;
   logic [15:0] ram_dia0;
   logic [15:0] ram_dob0 = 16'h0000;

   logic [15:0] mem     [1024];
   logic        written [1024];
   logic [4:0]  rr_exp = 5'b10101;

   int vecs = 0;
   int errs = 0;

   always #5 clka = ~clka;

   ram_port_arbiter #(.ADDR_W(10), .DATA_W(16), .RR_MODE(1)) dut (
      .clka(clka), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
      .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
   );

   ram_port_arbiter #(.ADDR_W(10), .DATA_W(16), .RR_MODE(0)) dut0 (
      .clka(clka), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt0), .f_rvalid(f_rvalid0), .f_rdata(f_rdata0),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt0), .d_rvalid(d_rvalid0), .d_rdata(d_rdata0),
      .ram_ena(ram_ena0), .ram_wea(ram_wea0), .ram_addra(ram_addra0), .ram_dia(ram_dia0),
      .ram_enb(ram_enb0), .ram_addrb(ram_addrb0), .ram_dob(ram_dob0)
   );

   // Read-first synchronous RAM; unwritten words read as 0xA000 + address.
   always @(posedge clka) begin
      if (ram_enb) begin
         if (written[ram_addrb] === 1'b1)
            ram_dob <= mem[ram_addrb];
         else
            ram_dob <= 16'hA000 + {6'd0, ram_addrb};
      end
      if (ram_ena && ram_wea) begin
         mem[ram_addra]     <= ram_dia;
         written[ram_addra] <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   initial begin
      rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      f_addr = 10'd0; d_addr = 10'd0; d_wdata = 16'h0000;

      // reset state
      #2;
      chk("rst_f_rvalid", f_rvalid, 1'b0);
      chk("rst_d_rvalid", d_rvalid, 1'b0);
      chk("rst_f_rdata", f_rdata, 16'h0000);
      chk("rst_d_rdata", d_rdata, 16'h0000);
      chk("rst_ram_ena", ram_ena, 1'b0);
      chk("rst_ram_wea", ram_wea, 1'b0);
      chk("rst_ram_enb", ram_enb, 1'b0);
      chk("rst_ram_addra", ram_addra, 10'd0);
      chk("rst_ram_addrb", ram_addrb, 10'd0);
      chk("rst_ram_dia", ram_dia, 16'h0000);
      f_req = 1'b1; d_req = 1'b1;
      #1;
      chk("rst_f_gnt", f_gnt, 1'b0);
      chk("rst_d_gnt", d_gnt, 1'b0);
      chk("rst_f_gnt0", f_gnt0, 1'b0);
      f_req = 1'b0; d_req = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // 1: fetch-only reads of 0,1,2 back to back
      tick(); f_req = 1'b1; f_addr = 10'd0; #1;
      chk("t1_f_gnt_a0", f_gnt, 1'b1);
      chk("t1_d_gnt_idle", d_gnt, 1'b0);
      tick(); f_addr = 10'd1; #1;
      chk("t1_f_gnt_a1", f_gnt, 1'b1);
      chk("t1_ram_enb", ram_enb, 1'b1);
      chk("t1_ram_addrb", ram_addrb, 10'd0);
      tick(); f_addr = 10'd2; #1;
      chk("t1_f_gnt_a2", f_gnt, 1'b1);
      chk("t1_f_rvalid0", f_rvalid, 1'b1);
      chk("t1_f_rdata0", f_rdata, 16'hA000);
      chk("t1_d_rvalid0", d_rvalid, 1'b0);
      tick(); f_req = 1'b0; #1;
      chk("t1_f_rvalid1", f_rvalid, 1'b1);
      chk("t1_f_rdata1", f_rdata, 16'hA001);
      tick(); #1;
      chk("t1_f_rvalid2", f_rvalid, 1'b1);
      chk("t1_f_rdata2", f_rdata, 16'hA002);
      chk("t1_d_rvalid2", d_rvalid, 1'b0);
      chk("t1_d_rdata", d_rdata, 16'h0000);
      tick(); #1;
      chk("t1_f_rvalid_end", f_rvalid, 1'b0);
      chk("t1_f_rdata_hold", f_rdata, 16'hA002);
      chk("t1_ram_enb_end", ram_enb, 1'b0);
      chk("t1_ram_addrb_hold", ram_addrb, 10'd2);

      // 2: write then fetch of the same address one cycle later
      tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 10'd5; d_wdata = 16'h1234; #1;
      chk("t2_d_gnt", d_gnt, 1'b1);
      tick(); d_req = 1'b0; d_we = 1'b0; f_req = 1'b1; f_addr = 10'd5; #1;
      chk("t2_f_gnt", f_gnt, 1'b1);
      chk("t2_ram_ena", ram_ena, 1'b1);
      chk("t2_ram_wea", ram_wea, 1'b1);
      chk("t2_ram_addra", ram_addra, 10'd5);
      chk("t2_ram_dia", ram_dia, 16'h1234);
      tick(); f_req = 1'b0; #1;
      chk("t2_ram_ena_off", ram_ena, 1'b0);
      chk("t2_ram_wea_off", ram_wea, 1'b0);
      tick(); #1;
      chk("t2_f_rvalid", f_rvalid, 1'b1);
      chk("t2_f_rdata", f_rdata, 16'h1234);

      // 3 and 5: write and fetch of addr 7 in the same cycle (read-first)
      tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 10'd7; d_wdata = 16'hBEEF;
      f_req = 1'b1; f_addr = 10'd7; #1;
      chk("t5_f_gnt", f_gnt, 1'b1);
      chk("t5_d_gnt", d_gnt, 1'b1);
      tick(); d_req = 1'b0; d_we = 1'b0; f_req = 1'b0; #1;
      chk("t5_ram_wea", ram_wea, 1'b1);
      chk("t5_ram_enb", ram_enb, 1'b1);
      chk("t5_ram_addra", ram_addra, 10'd7);
      chk("t5_ram_addrb", ram_addrb, 10'd7);
      tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 10'd7; #1;
      chk("t3_d_gnt_rd", d_gnt, 1'b1);
      chk("t3_f_rvalid", f_rvalid, 1'b1);
      chk("t3_f_rdata_old", f_rdata, 16'hA007);
      tick(); d_req = 1'b0; #1;
      tick(); #1;
      chk("t3_d_rvalid", d_rvalid, 1'b1);
      chk("t3_d_rdata_new", d_rdata, 16'hBEEF);
      chk("t3_f_rvalid_off", f_rvalid, 1'b0);
      chk("t3_f_rdata_hold", f_rdata, 16'hA007);

      // 4: contended reads held for five cycles
      tick(); f_req = 1'b1; f_addr = 10'd1; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd2;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         #1;
         chk($sformatf("t4_rr_f_gnt_%0d", i), f_gnt, rr_exp[i]);
         chk($sformatf("t4_rr_d_gnt_%0d", i), d_gnt, !rr_exp[i]);
         chk($sformatf("t4_fix_f_gnt_%0d", i), f_gnt0, 1'b0);
         chk($sformatf("t4_fix_d_gnt_%0d", i), d_gnt0, 1'b1);
         if (i == 2) begin
            chk("t4_f_rvalid", f_rvalid, 1'b1);
            chk("t4_f_rdata", f_rdata, 16'hA001);
            chk("t4_d_rvalid_off", d_rvalid, 1'b0);
         end else if (i == 3) begin
            chk("t4_d_rvalid", d_rvalid, 1'b1);
            chk("t4_d_rdata", d_rdata, 16'hA002);
            chk("t4_f_rvalid_off", f_rvalid, 1'b0);
         end
      end
      tick(); d_req = 1'b0; #1;
      chk("t4_fix_f_gnt_after", f_gnt0, 1'b1);
      chk("t4_fix_d_gnt_after", d_gnt0, 1'b0);
      tick(); f_req = 1'b0;
      tick(); tick(); tick();

      // 6: reset one cycle after a read (and write) grant
      f_req = 1'b1; f_addr = 10'd9; d_req = 1'b1; d_we = 1'b1; d_addr = 10'd9; d_wdata = 16'h5555; #1;
      chk("t6_f_gnt", f_gnt, 1'b1);
      chk("t6_d_gnt", d_gnt, 1'b1);
      tick(); rst = 1'b1; #1;
      chk("t6_rst_f_gnt", f_gnt, 1'b0);
      chk("t6_rst_d_gnt", d_gnt, 1'b0);
      chk("t6_rst_ram_ena", ram_ena, 1'b0);
      chk("t6_rst_ram_wea", ram_wea, 1'b0);
      chk("t6_rst_ram_enb", ram_enb, 1'b0);
      chk("t6_rst_ram_addra", ram_addra, 10'd0);
      chk("t6_rst_ram_addrb", ram_addrb, 10'd0);
      chk("t6_rst_ram_dia", ram_dia, 16'h0000);
      chk("t6_rst_f_rdata", f_rdata, 16'h0000);
      chk("t6_rst_d_rdata", d_rdata, 16'h0000);
      f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      tick(); #1;
      chk("t6_rst_f_rvalid", f_rvalid, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         chk($sformatf("t6_no_f_rvalid_%0d", i), f_rvalid, 1'b0);
         chk($sformatf("t6_no_d_rvalid_%0d", i), d_rvalid, 1'b0);
      end
      tick(); f_req = 1'b1; f_addr = 10'd9; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd3; #1;
      chk("t6_contest_f_gnt", f_gnt, 1'b1);
      chk("t6_contest_d_gnt", d_gnt, 1'b0);
      tick(); f_req = 1'b0; d_req = 1'b0; #1;
      tick(); #1;
      chk("t6_f_rvalid", f_rvalid, 1'b1);
      chk("t6_write_cancelled", f_rdata, 16'hA009);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
